// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and EX-side training signals of the branch target buffer.
// The pipeline drives through master; the predictor attaches through slave.
interface branch_predictor_if;
    logic [31:0] pc_if;
    logic        predicted_taken_if;
    logic [31:0] predicted_target_if;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_branch;
    logic        upd_jal;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        bp_clear;

    modport master (
        output pc_if, upd_valid, upd_pc, upd_branch, upd_jal, upd_taken, upd_target, bp_clear,
        input  predicted_taken_if, predicted_target_if
    );

    modport slave (
        input  pc_if, upd_valid, upd_pc, upd_branch, upd_jal, upd_taken, upd_target, bp_clear,
        output predicted_taken_if, predicted_target_if
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters. The lookup is combinational
// on the registered table; training from EX takes effect on the next clock edge.
module branch_predictor #(
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic                clk,
    input  logic                rst,
    branch_predictor_if.slave   bp
);
    localparam int unsigned ENTRIES = 1 << INDEX_BITS;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic                uncond_q [ENTRIES];

    logic [INDEX_BITS-1:0] rd_idx;
    logic [TAG_BITS-1:0]   rd_tag;
    logic                  rd_hit;
    logic                  rd_taken;

    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0]   up_tag;
    logic                  up_hit;

    logic                  ent_we;
    logic                  valid_d;
    logic [TAG_BITS-1:0]   tag_d;
    logic [31:0]           target_d;
    logic [1:0]            ctr_d;
    logic                  uncond_d;

    // Instruction-aligned PCs: the two low bits never select an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.pc_if[1:0], bp.upd_pc[1:0]};

    always_comb begin
        rd_idx   = bp.pc_if[INDEX_BITS+1:2];
        rd_tag   = bp.pc_if[31:INDEX_BITS+2];
        rd_hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_taken = rd_hit && (uncond_q[rd_idx] || ctr_q[rd_idx][1]);
        bp.predicted_taken_if  = rd_taken;
        bp.predicted_target_if = rd_taken ? target_q[rd_idx] : bp.pc_if + 32'd4;
    end

    always_comb begin
        up_idx   = bp.upd_pc[INDEX_BITS+1:2];
        up_tag   = bp.upd_pc[31:INDEX_BITS+2];
        up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        ent_we   = 1'b0;
        valid_d  = valid_q[up_idx];
        tag_d    = tag_q[up_idx];
        target_d = target_q[up_idx];
        ctr_d    = ctr_q[up_idx];
        uncond_d = uncond_q[up_idx];
        if (bp.upd_valid && (bp.upd_branch || bp.upd_jal)) begin
            if (up_hit) begin
                ent_we = 1'b1;
                if (bp.upd_jal) begin
                    ctr_d    = 2'b11;
                    uncond_d = 1'b1;
                    target_d = bp.upd_target;
                end else if (bp.upd_taken) begin
                    ctr_d    = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
                    target_d = bp.upd_target;
                end else begin
                    ctr_d    = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
                end
            end else if (bp.upd_taken) begin
                ent_we   = 1'b1;
                valid_d  = 1'b1;
                tag_d    = up_tag;
                target_d = bp.upd_target;
                uncond_d = bp.upd_jal;
                ctr_d    = bp.upd_jal ? 2'b11 : 2'b10;
            end
        end
    end

    // Clear only drops valid bits and takes priority over a same-cycle update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= '{default: 1'b0};
            tag_q    <= '{default: '0};
            target_q <= '{default: '0};
            ctr_q    <= '{default: 2'b01};
            uncond_q <= '{default: 1'b0};
        end else if (bp.bp_clear) begin
            valid_q  <= '{default: 1'b0};
        end else if (ent_we) begin
            valid_q[up_idx]  <= valid_d;
            tag_q[up_idx]    <= tag_d;
            target_q[up_idx] <= target_d;
            ctr_q[up_idx]    <= ctr_d;
            uncond_q[up_idx] <= uncond_d;
        end
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with 2-bit saturating counters, located in the IF stage.
- Looks up the current fetch PC every cycle and produces predicted_taken_if / predicted_target_if. These travel through the IF/ID register into the ID/EX register as predictedTaken/predictedTarget.
- Trained by the EX stage once a branch or JAL resolves, one update per cycle. Reads are combinational; writes are registered.

Parameters:
- INDEX_BITS, 4, log2 of entry count (16 entries); index = pc[INDEX_BITS+1:2].
- TAG_BITS, 26, equals 30-INDEX_BITS; tag = pc[31:INDEX_BITS+2].

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- pc_if  input  32  current fetch PC.
- predicted_taken_if  output  1  prediction for pc_if (combinational).
- predicted_target_if  output  32  predicted next PC for pc_if (combinational).
- upd_valid  input  1  EX-stage resolution valid this cycle (0 while EX holds a bubble or is stalled).
- upd_pc  input  32  PC of the resolved instruction.
- upd_branch  input  1  resolved instruction is a conditional branch.
- upd_jal  input  1  resolved instruction is JAL.
- upd_taken  input  1  actual outcome (always 1 for JAL).
- upd_target  input  32  actual target address.
- bp_clear  input  1  synchronous invalidate of all entries.

Behaviour:
- Entry fields: valid(1), tag(TAG_BITS), target(32), ctr(2), uncond(1).
- Reset (rst=0, asynchronous):
  - all valid=0, ctr=2'b01, tag/target/uncond=0.
  - Outputs therefore read taken=0 and target=pc_if+4.
- Lookup (combinational on the registered table):
  - hit = valid[idx] and tag[idx]==pc_if tag field.
  - predicted_taken_if = hit and (uncond[idx] or ctr[idx][1]).
  - predicted_target_if = target[idx] when predicted_taken_if, otherwise pc_if+4 (32-bit wrap: 0xFFFFFFFC+4 = 0).
  - There is no lookup latency.
- Update, on the clock edge when upd_valid and (upd_branch or upd_jal); all other update cycles are ignored:
  - Hit on upd_pc, conditional branch:
    - taken: ctr saturating +1 (max 3), target <= upd_target.
    - not taken: ctr saturating -1 (min 0), target unchanged.
  - Hit on upd_pc, JAL: ctr <= 3, uncond <= 1, target <= upd_target.
  - Miss (invalid entry or tag mismatch), taken:
    - allocate/overwrite: valid=1, tag, target=upd_target.
    - uncond=upd_jal; ctr=3 for JAL, 2'b10 for a branch.
  - Miss, not taken: no allocation; table unchanged.
  - JALR and other instructions are never allocated and never predicted by this block.
- Simultaneous lookup and update to the same index: lookup returns the pre-update contents; the new contents are visible from the next cycle.
- bp_clear: all valid <= 0 on the edge; ctr and other fields are untouched.
  - If bp_clear coincides with an update, bp_clear wins and nothing is allocated.
- Flagged or invalid upd_* values with upd_valid=0 never change state.
- Reset asserted mid-operation clears the table immediately, independent of clk.

Test Plan:
- Reset, then pc_if=0x100 -> predicted_taken_if=0, predicted_target_if=0x104. Sweep pc_if=0xFFFFFFFC -> target 0x00000000.
- Taken branch at 0x100, target 0x80 -> next cycle pc_if=0x100 gives taken=1 (ctr=2), target 0x80. Two not-taken updates -> ctr=0, taken=0, target 0x104.
- Saturation: 5 taken updates at 0x200 -> ctr stays 3. One not-taken -> ctr=2, still predicts taken.
- Aliasing: allocate 0x100 (idx 0). Taken update at 0x140 (same idx, different tag) -> 0x140 hits with its own target; 0x100 now misses (taken=0).
- JAL at 0x300, target 0x400 -> taken=1. A following upd_branch-style not-taken with upd_jal=0 on the same PC leaves uncond=1, so it still predicts taken.
- Same-cycle lookup and update at 0x100 -> that cycle shows old prediction, next cycle shows new. bp_clear together with an update -> all lookups miss afterwards. Asserting rst mid-run -> outputs revert to taken=0 without a clock edge.
